// File: rtl/fa_pkg.sv
// fa_pkg: shared widths, the registered result pair and a behavioural
// reference adder for the full_adder leaf cell.
package fa_pkg;

  localparam int FA_SUM_W   = 1;
  localparam int FA_CARRY_W = 1;
  localparam int FA_RES_W   = FA_SUM_W + FA_CARRY_W;

  // Sum/carry pair held by the output register stage.
  typedef struct packed {
    logic s;
    logic c;
  } fa_result_t;

  // Behavioural reference: {carry, sum} as a plain 2-bit addition.
  function automatic logic [FA_RES_W-1:0] fa_ref_add(input logic a,
                                                     input logic b,
                                                     input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/fa_half_adder.sv
// fa_half_adder: gate-level half adder cell.
// Ports:
//   x, y : input bits
//   s    : sum   (x ^ y)
//   c    : carry (x & y)
module fa_half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/full_adder.sv
// full_adder: single-bit full adder built from two half-adder cells and an
// OR gate, with an optional valid-qualified output register stage.
// Parameters:
//   REG_OUT   : 1 = S_q/Cout_q/out_valid are flops (1-cycle latency),
//               0 = combinational pass-throughs of S/Cout/in_valid.
// Ports:
//   clk, rst          : clock and asynchronous active-high reset
//   a, b, Cin         : addend bits and carry in
//   in_valid          : qualifies a/b/Cin for the registered stage
//   S, Cout           : combinational sum / carry out
//   S_q, Cout_q       : registered (or passed-through) sum / carry out
//   out_valid         : S_q/Cout_q hold a valid result
//   err               : sticky self-check error
// Build option:
//   FA_SELF_CHECK_EN  : when defined, a behavioural reference adder is
//                       compared against {Cout,S} on every valid cycle and a
//                       mismatch sets err until rst; otherwise err is tied 0.
module full_adder
  import fa_pkg::*;
#(
  parameter int REG_OUT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic Cin,
  input  logic in_valid,
  output logic S,
  output logic Cout,
  output logic S_q,
  output logic Cout_q,
  output logic out_valid,
  output logic err
);

  logic p_s;
  logic g1_s;
  logic g2_s;

  // First half adder: propagate and generate of the two addend bits.
  fa_half_adder u_ha1 (
    .x (a),
    .y (b),
    .s (p_s),
    .c (g1_s)
  );

  // Second half adder folds in the carry.
  fa_half_adder u_ha2 (
    .x (p_s),
    .y (Cin),
    .s (S),
    .c (g2_s)
  );

  assign Cout = g1_s | g2_s;

  generate
    if (REG_OUT != 0) begin : g_reg
      fa_result_t result_r;
      logic       valid_r;

      // Output stage: valid follows in_valid every cycle, data loads only on valid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          result_r <= '{s: 1'b0, c: 1'b0};
          valid_r  <= 1'b0;
        end else begin
          valid_r <= in_valid;
          if (in_valid) begin
            result_r.s <= S;
            result_r.c <= Cout;
          end
        end
      end

      assign S_q       = result_r.s;
      assign Cout_q    = result_r.c;
      assign out_valid = valid_r;
    end else begin : g_comb
      assign S_q       = S;
      assign Cout_q    = Cout;
      assign out_valid = in_valid;
    end
  endgenerate

`ifdef FA_SELF_CHECK_EN
  logic [FA_RES_W-1:0] ref_s;
  logic                err_r;

  assign ref_s = fa_ref_add(a, b, Cin);

  // Sticky error flag: any valid cycle where the gate netlist disagrees
  // with the arithmetic reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (in_valid && (ref_s != {Cout, S})) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: randomized and directed self-checking bench for full_adder.
// Two instances share the inputs: dut_r (REG_OUT=1) and dut_c (REG_OUT=0).
// Expected values come from 2-bit arithmetic and a small cycle model.
module tb_full_adder;

  logic clk;
  logic rst;
  logic a, b, cin, in_valid;

  logic s_r, cout_r, s_q_r, cout_q_r, out_valid_r, err_r;
  logic s_c, cout_c, s_q_c, cout_q_c, out_valid_c, err_c;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Registered-stage model state.
  logic m_valid, m_s, m_c;

  full_adder #(.REG_OUT(1)) dut_r (
    .clk(clk), .rst(rst), .a(a), .b(b), .Cin(cin), .in_valid(in_valid),
    .S(s_r), .Cout(cout_r), .S_q(s_q_r), .Cout_q(cout_q_r),
    .out_valid(out_valid_r), .err(err_r)
  );

  full_adder #(.REG_OUT(0)) dut_c (
    .clk(clk), .rst(rst), .a(a), .b(b), .Cin(cin), .in_valid(in_valid),
    .S(s_c), .Cout(cout_c), .S_q(s_q_c), .Cout_q(cout_q_c),
    .out_valid(out_valid_c), .err(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [1:0] ref_add(input logic x, input logic y, input logic z);
    int total;
    total = int'(x) + int'(y) + int'(z);
    return total[1:0];
  endfunction

  // Combinational outputs of both instances against the reference.
  task automatic check_comb(input string tag);
    logic [1:0] e;
    e = ref_add(a, b, cin);
    check_bit({tag, "_S"},       s_r,         e[0]);
    check_bit({tag, "_Cout"},    cout_r,      e[1]);
    check_bit({tag, "_S_c"},     s_c,         e[0]);
    check_bit({tag, "_Cout_c"},  cout_c,      e[1]);
    check_bit({tag, "_Sq_c"},    s_q_c,       e[0]);
    check_bit({tag, "_Coutq_c"}, cout_q_c,    e[1]);
    check_bit({tag, "_vld_c"},   out_valid_c, in_valid);
  endtask

  task automatic check_reg(input string tag);
    check_bit({tag, "_Sq"},    s_q_r,       m_s);
    check_bit({tag, "_Coutq"}, cout_q_r,    m_c);
    check_bit({tag, "_vld"},   out_valid_r, m_valid);
    check_bit({tag, "_err"},   err_r,       1'b0);
    check_bit({tag, "_err_c"}, err_c,       1'b0);
  endtask

  // One clock cycle: drive at the falling edge, check comb, clock, check regs.
  task automatic cycle(input string tag, input logic va, input logic vb,
                       input logic vc, input logic vv);
    logic [1:0] e;
    a = va; b = vb; cin = vc; in_valid = vv;
    #1;
    check_comb(tag);
    @(posedge clk);
    e = ref_add(va, vb, vc);
    m_valid = vv;
    if (vv) begin
      m_s = e[0];
      m_c = e[1];
    end
    #1;
    check_reg(tag);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] pat;
    rst = 1'b1; a = 1'b0; b = 1'b0; cin = 1'b0; in_valid = 1'b0;
    m_valid = 1'b0; m_s = 1'b0; m_c = 1'b0;

    @(negedge clk);
    check_reg("reset");
    check_comb("reset");
    rst = 1'b0;

    // Exhaustive sweep with in_valid=1.
    for (int i = 0; i < 8; i++) begin
      pat = 3'(i);
      cycle("sweep", pat[2], pat[1], pat[0], 1'b1);
    end
    // Directed truth-table spot checks.
    cycle("tt011", 1'b0, 1'b1, 1'b1, 1'b1);
    check_bit("tt011_Sq", s_q_r, 1'b0);
    check_bit("tt011_Coutq", cout_q_r, 1'b1);
    cycle("tt111", 1'b1, 1'b1, 1'b1, 1'b1);
    check_bit("tt111_Sq", s_q_r, 1'b1);
    check_bit("tt111_Coutq", cout_q_r, 1'b1);

    // Latency: 101 valid, then idle holds data and drops valid.
    cycle("lat", 1'b1, 1'b0, 1'b1, 1'b1);
    check_bit("lat_Sq", s_q_r, 1'b0);
    check_bit("lat_Coutq", cout_q_r, 1'b1);
    check_bit("lat_vld", out_valid_r, 1'b1);
    cycle("hold", 1'b0, 1'b0, 1'b0, 1'b0);
    check_bit("hold_vld", out_valid_r, 1'b0);
    check_bit("hold_Coutq", cout_q_r, 1'b1);

    // Back-to-back throughput 110, 001, 111.
    cycle("b2b0", 1'b1, 1'b1, 1'b0, 1'b1);
    check_bit("b2b0_SC", (s_q_r == 1'b0) && (cout_q_r == 1'b1) && out_valid_r, 1'b1);
    cycle("b2b1", 1'b0, 1'b0, 1'b1, 1'b1);
    check_bit("b2b1_SC", (s_q_r == 1'b1) && (cout_q_r == 1'b0) && out_valid_r, 1'b1);
    cycle("b2b2", 1'b1, 1'b1, 1'b1, 1'b1);
    check_bit("b2b2_SC", (s_q_r == 1'b1) && (cout_q_r == 1'b1) && out_valid_r, 1'b1);

    // Async reset between edges while holding a valid S_q=1 result.
    cycle("pre_rst", 1'b1, 1'b0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    m_valid = 1'b0; m_s = 1'b0; m_c = 1'b0;
    check_reg("async_rst");
    a = 1'b1; b = 1'b1; cin = 1'b0;
    #0.5;
    check_comb("rst_track");
    in_valid = 1'b0;
    #0.5;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_reg("post_rst_idle");
    @(negedge clk);
    cycle("post_rst_first", 1'b0, 1'b1, 1'b0, 1'b1);

    // Randomized stimulus with random valid gaps.
    for (int i = 0; i < 200; i++) begin
      cycle("rand", 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
